// File: rtl/multiplier_pkg.sv
// Shared types and defaults for the multiplier sequencer.
// Holds the FSM state set and the counter sizing helper.
package multiplier_pkg;

    localparam int XW_DEF      = 12;
    localparam int ZW_DEF      = 2 * XW_DEF;
    localparam int TIMEOUT_DEF = 64;

    // Wide enough for the longest count any state loads, plus one.
    function automatic int cnt_width(input int zw, input int to);
        int m;
        m = (zw + 1 > to) ? zw + 1 : to;
        return $clog2(m + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(ZW_DEF, TIMEOUT_DEF);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        MUL    = 3'd2,
        WAIT   = 3'd3,
        UNLOAD = 3'd4,
        RESULT = 3'd5
    } state_e;

endpackage

// File: rtl/seq_counter.sv
// Loadable down-counter shared by all timed sequencer states.
// last flags the cycle whose decrement brings the count to zero.
module seq_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load wins over decrement; the count never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == W'(1));

endmodule

// File: rtl/multiplier_sequencer.sv
// Host-side sequencer for a bit-serial multiplier: shifts operands out,
// waits for completion with a timeout, then shifts the product back in.
module multiplier_sequencer
    import multiplier_pkg::*;
#(
    parameter int XW      = XW_DEF,
    parameter int ZW      = ZW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] op_x,
    input  logic [XW-1:0] op_y,
    output logic          busy,
    output logic [ZW-1:0] result,
    output logic          res_valid,
    output logic          err,
    input  logic          res_ack,
    output logic          x_ser,
    output logic          sx,
    output logic          y_ser,
    output logic          sy,
    output logic          mul,
    input  logic          mul_done,
    output logic          sz,
    input  logic          z_ser
);

    localparam int CW = cnt_width(ZW, TIMEOUT);

    localparam logic [CW-1:0] LOAD_N = CW'(XW);
    localparam logic [CW-1:0] WAIT_N = CW'(TIMEOUT);
    localparam logic [CW-1:0] UNLD_N = CW'(ZW + 1);
    localparam logic [CW-1:0] TWO    = CW'(2);

    state_e        state_q;
    state_e        state_d;
    logic [XW-1:0] x_sh_q;
    logic [XW-1:0] x_sh_d;
    logic [XW-1:0] y_sh_q;
    logic [XW-1:0] y_sh_d;
    logic [ZW-2:0] z_sh_q;
    logic [ZW-2:0] z_sh_d;
    logic [ZW-1:0] result_q;
    logic [ZW-1:0] result_d;
    logic          err_q;
    logic          err_d;
    logic          busy_q;
    logic          busy_d;
    logic          res_valid_q;
    logic          res_valid_d;
    logic          mul_q;
    logic          mul_d;
    logic          sxy_q;
    logic          sxy_d;
    logic          sz_q;
    logic          sz_d;
    logic          x_ser_q;
    logic          x_ser_d;
    logic          y_ser_q;
    logic          y_ser_d;

    logic          cnt_load;
    logic [CW-1:0] cnt_val;
    logic          cnt_dec;
    logic [CW-1:0] cnt_q;
    logic          cnt_last;

    seq_counter #(
        .W (CW)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .count    (cnt_q),
        .last     (cnt_last)
    );

    // Next state and next registered outputs, aligned to the next state.
    always_comb begin
        state_d  = state_q;
        x_sh_d   = x_sh_q;
        y_sh_d   = y_sh_q;
        z_sh_d   = z_sh_q;
        result_d = result_q;
        err_d    = err_q;
        mul_d    = 1'b0;
        sxy_d    = 1'b0;
        sz_d     = 1'b0;
        x_ser_d  = 1'b0;
        y_ser_d  = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = LOAD;
                    cnt_load = 1'b1;
                    cnt_val  = LOAD_N;
                    sxy_d    = 1'b1;
                    x_ser_d  = op_x[XW-1];
                    y_ser_d  = op_y[XW-1];
                    x_sh_d   = {op_x[XW-2:0], 1'b0};
                    y_sh_d   = {op_y[XW-2:0], 1'b0};
                end
            end
            LOAD: begin
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    state_d = MUL;
                    mul_d   = 1'b1;
                end else begin
                    sxy_d   = 1'b1;
                    x_ser_d = x_sh_q[XW-1];
                    y_ser_d = y_sh_q[XW-1];
                    x_sh_d  = {x_sh_q[XW-2:0], 1'b0};
                    y_sh_d  = {y_sh_q[XW-2:0], 1'b0};
                end
            end
            MUL: begin
                state_d  = WAIT;
                cnt_load = 1'b1;
                cnt_val  = WAIT_N;
            end
            WAIT: begin
                cnt_dec = 1'b1;
                if (mul_done) begin
                    state_d  = UNLOAD;
                    cnt_load = 1'b1;
                    cnt_val  = UNLD_N;
                    sz_d     = 1'b1;
                    z_sh_d   = '0;
                end else if (cnt_last) begin
                    state_d  = RESULT;
                    err_d    = 1'b1;
                    result_d = '0;
                end
            end
            UNLOAD: begin
                cnt_dec = 1'b1;
                // The product lags sz by one cycle, so skip the first.
                if (cnt_q != UNLD_N) begin
                    z_sh_d = {z_sh_q[ZW-3:0], z_ser};
                end
                if (cnt_last) begin
                    state_d  = RESULT;
                    err_d    = 1'b0;
                    result_d = {z_sh_q, z_ser};
                end else begin
                    sz_d = (cnt_q > TWO);
                end
            end
            RESULT: begin
                if (res_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d != IDLE);
        res_valid_d = (state_d == RESULT);
    end

    // FSM state, shift registers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            x_sh_q      <= '0;
            y_sh_q      <= '0;
            z_sh_q      <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            mul_q       <= 1'b0;
            sxy_q       <= 1'b0;
            sz_q        <= 1'b0;
            x_ser_q     <= 1'b0;
            y_ser_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_sh_q      <= x_sh_d;
            y_sh_q      <= y_sh_d;
            z_sh_q      <= z_sh_d;
            result_q    <= result_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            mul_q       <= mul_d;
            sxy_q       <= sxy_d;
            sz_q        <= sz_d;
            x_ser_q     <= x_ser_d;
            y_ser_q     <= y_ser_d;
        end
    end

    assign busy      = busy_q;
    assign result    = result_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;
    assign mul       = mul_q;
    assign sx        = sxy_q;
    assign sy        = sxy_q;
    assign sz        = sz_q;
    assign x_ser     = x_ser_q;
    assign y_ser     = y_ser_q;

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Bench for multiplier_sequencer: serial multiplier model, timeline
// reference model with per-cycle compare, directed and random runs.
module tb_multiplier_sequencer;

    localparam int XW = 12;
    localparam int ZW = 24;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          res_ack = 1'b0;
    logic          mul_done = 1'b0;
    logic          z_ser = 1'b0;
    logic [XW-1:0] op_x = '0;
    logic [XW-1:0] op_y = '0;
    logic          busy;
    logic          res_valid;
    logic          err;
    logic          x_ser;
    logic          sx;
    logic          y_ser;
    logic          sy;
    logic          mul;
    logic          sz;
    logic [ZW-1:0] result;

    int total = 0;
    int bad = 0;
    int dly = 1;

    always #5 clk = ~clk;

    multiplier_sequencer #(
        .XW      (XW),
        .ZW      (ZW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_x      (op_x),
        .op_y      (op_y),
        .busy      (busy),
        .result    (result),
        .res_valid (res_valid),
        .err       (err),
        .res_ack   (res_ack),
        .x_ser     (x_ser),
        .sx        (sx),
        .y_ser     (y_ser),
        .sy        (sy),
        .mul       (mul),
        .mul_done  (mul_done),
        .sz        (sz),
        .z_ser     (z_ser)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    // Serial multiplier model: gathers operand bits, answers mul after
    // dly cycles (0 = pulse in the mul cycle, <0 = never), and returns
    // the product MSB first one cycle after each sz.
    logic signed [XW-1:0] xcol = '0;
    logic signed [XW-1:0] ycol = '0;
    logic signed [ZW-1:0] prod = '0;
    int   ecnt = -1;
    int   zi = 0;
    logic zprev = 1'b0;
    int   mul_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mul_done = 1'b0;
                z_ser    = 1'b0;
                ecnt     = -1;
                zprev    = 1'b0;
            end else begin
                mul_done = 1'b0;
                if (sx) xcol = {xcol[XW-2:0], x_ser};
                if (sy) ycol = {ycol[XW-2:0], y_ser};
                if (mul) begin
                    mul_cnt++;
                    prod = xcol * ycol;
                    zi   = ZW - 1;
                    ecnt = dly;
                    if (dly == 0) mul_done = 1'b1;
                end else if (ecnt > 0) begin
                    ecnt--;
                    if (ecnt == 0) mul_done = 1'b1;
                end
                if (zprev && zi >= 0) begin
                    z_ser = prod[zi];
                    zi--;
                end else begin
                    z_ser = 1'b0;
                end
                zprev = sz;
            end
        end
    end

    // Timeline reference: offsets from the accept edge decide the phase.
    int            cyc = 0;
    bit            m_act = 0;
    bit            m_ok = 0;
    int            m_a = 0;
    int            m_w = 0;
    int            m_ro = 0;
    int            o = 0;
    int            u = 0;
    logic [XW-1:0] m_x = '0;
    logic [XW-1:0] m_y = '0;
    logic [ZW-1:0] m_p = '0;
    logic [7:0]    ev;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                m_act = 0;
            end else if (!m_act) begin
                if (start) begin
                    m_act = 1;
                    m_a   = cyc;
                    m_x   = op_x;
                    m_y   = op_y;
                    m_ok  = (dly >= 1) && (dly <= TO);
                    m_w   = m_ok ? dly : TO;
                    m_ro  = m_ok ? XW + 3 + m_w + ZW : XW + 2 + TO;
                    m_p   = m_ok ? ZW'($signed(op_x) * $signed(op_y)) : '0;
                end
            end else if ((cyc - m_a >= m_ro) && res_ack) begin
                m_act = 0;
            end
            @(negedge clk);
            ev = '0;
            if (m_act) begin
                o     = cyc - m_a + 1;
                ev[7] = 1'b1;
                if (o <= XW) begin
                    ev[4] = 1'b1;
                    ev[3] = 1'b1;
                    ev[1] = m_x[XW-o];
                    ev[0] = m_y[XW-o];
                end else if (o == XW + 1) begin
                    ev[5] = 1'b1;
                end else if (o >= m_ro) begin
                    ev[6] = 1'b1;
                end else if (m_ok && o >= XW + 2 + m_w) begin
                    u     = o - (XW + 1 + m_w);
                    ev[2] = (u <= ZW);
                end
            end
            check("outs", {24'd0, busy, res_valid, mul, sx, sy, sz,
                           x_ser, y_ser}, {24'd0, ev});
            if (ev[6]) begin
                check("result", {8'd0, result}, {8'd0, m_p});
                check("err", {31'd0, err}, {31'd0, !m_ok});
            end
        end
    end

    task automatic wait_valid(output logic [ZW-1:0] r, output logic e);
        int n;
        n = 0;
        while (!res_valid && n < 300) begin
            step;
            n++;
        end
        check("res_valid_seen", {31'd0, res_valid}, 32'd1);
        r = result;
        e = err;
    endtask

    task automatic ack;
        res_ack = 1'b1;
        step;
        res_ack = 1'b0;
    endtask

    task automatic run(input logic [XW-1:0] x, input logic [XW-1:0] y,
                       input int d, output logic [ZW-1:0] r,
                       output logic e);
        op_x  = x;
        op_y  = y;
        dly   = d;
        start = 1'b1;
        step;
        start = 1'b0;
        op_x  = XW'($urandom);
        op_y  = XW'($urandom);
        wait_valid(r, e);
        repeat ($urandom_range(0, 2)) step;
        ack;
    endtask

    task automatic wait_sig_mul(input int lim);
        int n;
        n = 0;
        while (!mul && n < lim) begin
            step;
            n++;
        end
        check("mul_seen", {31'd0, mul}, 32'd1);
    endtask

    task automatic wait_sig_sz(input int lim);
        int n;
        n = 0;
        while (!sz && n < lim) begin
            step;
            n++;
        end
        check("sz_seen", {31'd0, sz}, 32'd1);
    endtask

    logic [ZW-1:0] r;
    logic          e;
    logic [XW-1:0] rx;
    logic [XW-1:0] ry;
    logic [ZW-1:0] pexp;
    int            n;
    int            c0;
    int            d;

    initial begin
        step;
        step;
        check("rst_outs", {23'd0, busy, res_valid, mul, sx, sy, sz,
                           x_ser, y_ser, err}, 32'd0);
        check("rst_result", {8'd0, result}, 32'd0);

        // Release and start on the same cycle; known operand pattern.
        rst = 1'b1;
        run(12'h003, 12'hFFE, 5, r, e);
        check("t1_xbits", {20'd0, xcol}, 32'h003);
        check("t1_ybits", {20'd0, ycol}, 32'hFFE);
        check("t1_result", {8'd0, r}, 32'hFFFFFA);
        check("t1_err", {31'd0, e}, 32'd0);

        // No mul_done at all: timeout.
        op_x  = 12'h055;
        op_y  = 12'h0AA;
        dly   = -1;
        start = 1'b1;
        step;
        start = 1'b0;
        wait_sig_mul(50);
        n = 0;
        while (!res_valid && n < 200) begin
            step;
            n++;
        end
        check("t2_timeout_cycles", n, TO + 1);
        check("t2_err", {31'd0, err}, 32'd1);
        check("t2_result", {8'd0, result}, 32'd0);
        ack;

        // Start pulses while busy are ignored.
        c0    = mul_cnt;
        rx    = 12'h123;
        ry    = 12'hF45;
        op_x  = rx;
        op_y  = ry;
        dly   = 4;
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        step;
        op_x  = 12'h7FF;
        start = 1'b1;
        step;
        start = 1'b0;
        wait_sig_mul(30);
        step;
        step;
        start = 1'b1;
        step;
        start = 1'b0;
        wait_sig_sz(30);
        step;
        start = 1'b1;
        step;
        start = 1'b0;
        wait_valid(r, e);
        check("t3_mul_pulses", mul_cnt - c0, 1);
        pexp = ZW'($signed(rx) * $signed(ry));
        check("t3_result", {8'd0, r}, {8'd0, pexp});
        ack;

        // Reset in UNLOAD cycle 10, then a normal run.
        op_x  = 12'h321;
        op_y  = 12'h456;
        dly   = 3;
        start = 1'b1;
        step;
        start = 1'b0;
        wait_sig_sz(60);
        repeat (9) step;
        rst = 1'b0;
        #1;
        check("t4_rst_outs", {23'd0, busy, res_valid, mul, sx, sy, sz,
                              x_ser, y_ser, err}, 32'd0);
        check("t4_rst_result", {8'd0, result}, 32'd0);
        step;
        step;
        check("t4_no_valid", {31'd0, res_valid}, 32'd0);
        rst = 1'b1;
        run(12'h7FF, 12'h7FF, 2, r, e);
        check("t4_after_result", {8'd0, r}, 32'h3FF001);

        // ack and start together: back to idle, no new run.
        run_keep:
        begin
            op_x  = 12'h005;
            op_y  = 12'h007;
            dly   = 2;
            start = 1'b1;
            step;
            start = 1'b0;
            wait_valid(r, e);
            check("t5_first", {8'd0, r}, 32'h23);
            res_ack = 1'b1;
            start   = 1'b1;
            op_x    = 12'h123;
            step;
            res_ack = 1'b0;
            check("t5_idle", {31'd0, busy}, 32'd0);
            op_x    = 12'h800;
            op_y    = 12'h800;
            step;
            start   = 1'b0;
            wait_valid(r, e);
            check("t5_result", {8'd0, r}, 32'h400000);
            check("t5_err", {31'd0, e}, 32'd0);
            ack;
        end

        // mul_done only in the MUL cycle: timeout path.
        run(12'h010, 12'h010, 0, r, e);
        check("t6_err", {31'd0, e}, 32'd1);
        check("t6_result", {8'd0, r}, 32'd0);

        // Completion on the last WAIT cycle, and one cycle too late.
        run(12'hFFF, 12'hFFF, TO, r, e);
        check("edge_last_err", {31'd0, e}, 32'd0);
        check("edge_last_result", {8'd0, r}, 32'd1);
        run(12'h002, 12'h003, TO + 1, r, e);
        check("edge_late_err", {31'd0, e}, 32'd1);

        // Random operands and delays.
        for (int i = 0; i < 12; i++) begin
            rx = XW'($urandom);
            ry = XW'($urandom);
            if (i % 4 == 3) begin
                d = (i == 3) ? 0 : (i == 7) ? TO : TO + 1;
            end else begin
                d = $urandom_range(1, 12);
            end
            run(rx, ry, d, r, e);
            pexp = (d >= 1 && d <= TO) ? ZW'($signed(rx) * $signed(ry)) : '0;
            check("rand_result", {8'd0, r}, {8'd0, pexp});
        end

        repeat (3) step;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
